// File: rtl/display_sched.sv
// Round-robin scheduler that shares one hex display among N_SRC voltage-level
// requesters; each granted level is shown for DWELL cycles before the next grant.
module display_sched #(
  parameter int          N_SRC = 4,
  parameter int          LVL_W = 8,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*LVL_W-1:0] src_level,
  output logic [N_SRC-1:0]       src_ready,
  input  logic                   force_en,
  input  logic [1:0]             force_src,
  input  logic                   freeze,
  output logic [LVL_W-1:0]       disp_level,
  output logic                   disp_valid,
  output logic [1:0]             disp_src,
  output logic                   disp_busy,
  output logic [1:0]             dbg_state
);

  // Handshake: source i transfers at a rising edge where src_valid[i] & src_ready[i];
  // src_ready[i] is simply "capture buffer i is empty".

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHOW = 2'd2} state_e;

  localparam logic [31:0] DWELL_M1 = 32'(DWELL - 1);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   pending_q;
  logic [LVL_W-1:0]   lvl_buf_q [N_SRC];
  logic [1:0]         last_src_q;
  logic [1:0]         grant_q, grant_d;
  logic [31:0]        cnt_q;
  logic [LVL_W-1:0]   disp_level_q;
  logic               disp_valid_q;
  logic [1:0]         disp_src_q;
  logic [N_SRC-1:0]   force_mask;
  logic [N_SRC-1:0]   eligible;
  logic               any_elig;
  logic [1:0]         idx;

  assign src_ready  = ~pending_q;
  assign disp_level = disp_level_q;
  assign disp_valid = disp_valid_q;
  assign disp_src   = disp_src_q;

  // Round-robin search starting just after the last displayed source.
  always_comb begin
    force_mask            = '0;
    force_mask[force_src] = 1'b1;
    eligible              = force_en ? (pending_q & force_mask) : pending_q;
    any_elig              = |eligible;
    grant_d               = grant_q;
    idx                   = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = last_src_q + 2'(k);
      if (eligible[idx]) grant_d = idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig) state_d = LOAD;
      LOAD:    state_d = SHOW;
      SHOW:    if (!freeze && cnt_q == DWELL_M1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp_busy = (state_q != IDLE);
    dbg_state = state_q;
  end

  // Capture buffers; the granted entry is released during LOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q <= '0;
      for (int i = 0; i < N_SRC; i++) lvl_buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_valid[i] && !pending_q[i]) begin
          pending_q[i] <= 1'b1;
          lvl_buf_q[i] <= src_level[i*LVL_W +: LVL_W];
        end
      end
      if (state_q == LOAD) pending_q[grant_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q      <= '0;
      last_src_q   <= 2'd3;
      cnt_q        <= '0;
      disp_level_q <= '0;
      disp_valid_q <= 1'b0;
      disp_src_q   <= '0;
    end else begin
      disp_valid_q <= 1'b0;
      if (state_q == IDLE && any_elig) grant_q <= grant_d;
      if (state_q == LOAD) begin
        disp_level_q <= lvl_buf_q[grant_q];
        disp_src_q   <= grant_q;
        disp_valid_q <= 1'b1;
        last_src_q   <= grant_q;
        cnt_q        <= '0;
      end else if (state_q == SHOW && !freeze) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_sched.sv
// Bench for display_sched: directed scenarios plus randomized traffic, checked
// every cycle against a time-budget model of the display schedule.
module tb_display_sched;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_level = '0;
  logic [3:0]  src_ready;
  logic        force_en = 1'b0;
  logic [1:0]  force_src = '0;
  logic        freeze = 1'b0;
  logic [7:0]  disp_level;
  logic        disp_valid;
  logic [1:0]  disp_src;
  logic        disp_busy;
  logic [1:0]  dbg_state;

  display_sched #(.N_SRC(4), .LVL_W(8), .DWELL(DW)) dut (
    .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_level(src_level),
    .src_ready(src_ready), .force_en(force_en), .force_src(force_src),
    .freeze(freeze), .disp_level(disp_level), .disp_valid(disp_valid),
    .disp_src(disp_src), .disp_busy(disp_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A grant occupies the display for a budget of 1 load cycle + DW show cycles;
  // frozen show cycles do not spend the budget.
  logic [3:0] m_pend = '0;
  logic [7:0] m_buf [4] = '{default: 8'h00};
  int         m_last = 3;
  int         m_g = 0;
  int         m_left = 0;
  logic [7:0] m_lvl = '0;
  logic [1:0] m_src = '0;
  logic       m_valid = 1'b0;

  always @(posedge clk or negedge rstn) begin
    logic [3:0] old;
    logic [3:0] el;
    bit found;
    int j;
    if (!rstn) begin
      m_pend = '0; m_last = 3; m_g = 0; m_left = 0;
      m_lvl = '0; m_src = '0; m_valid = 1'b0;
      for (int i = 0; i < 4; i++) m_buf[i] = '0;
    end else begin
      old = m_pend;
      m_valid = 1'b0;
      if (m_left == DW + 1) begin
        m_lvl = m_buf[m_g]; m_src = 2'(m_g); m_valid = 1'b1;
        m_last = m_g; m_pend[m_g] = 1'b0; m_left--;
      end else if (m_left > 0) begin
        if (!freeze) m_left--;
      end else begin
        el = force_en ? (old & (4'b0001 << force_src)) : old;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          j = (m_last + k) % 4;
          if (!found && el[j]) begin found = 1; m_g = j; end
        end
        if (found) m_left = DW + 1;
      end
      for (int i = 0; i < 4; i++)
        if (src_valid[i] && !old[i]) begin
          m_pend[i] = 1'b1;
          m_buf[i]  = src_level[i*8 +: 8];
        end
    end
  end

  // ---------------- compare / monitor ----------------
  int ev_src[$];
  int ev_lvl[$];
  int ev_cyc[$];
  int busy_runs[$];
  int run = 0;

  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    if (chk_en) begin
      exp_rdy = ~m_pend;
      check("src_ready",  src_ready,  exp_rdy);
      check("disp_valid", disp_valid, m_valid);
      check("disp_level", disp_level, m_lvl);
      check("disp_src",   disp_src,   m_src);
      check("disp_busy",  disp_busy,  (m_left > 0));
    end
    if (disp_valid) begin
      ev_src.push_back(disp_src); ev_lvl.push_back(disp_level); ev_cyc.push_back(cyc);
    end
    if (disp_busy) run++;
    else if (run > 0) begin busy_runs.push_back(run); run = 0; end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    ev_src.delete(); ev_lvl.delete(); ev_cyc.delete(); busy_runs.delete(); run = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0; src_valid = '0; force_en = 0; freeze = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    clear_logs();
  endtask

  task automatic offer(input logic [3:0] mask, input logic [31:0] lv, output int t);
    @(posedge clk); #2;
    src_valid = mask; src_level = lv;
    @(posedge clk); #1;
    t = cyc;
    #1 src_valid = '0;
  endtask

  task automatic wait_ev(input int n, input int max, input string name);
    for (int k = 0; k < max && ev_src.size() < n; k++) @(negedge clk);
    check(name, (ev_src.size() >= n), 1);
  endtask

  task automatic wait_run(input int max);
    for (int k = 0; k < max && busy_runs.size() < 1; k++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    #1 rstn = 1'b0;
    #1 chk_en = 1'b1;
    #20;
    @(posedge clk); #2 rstn = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_ready", src_ready, 4'hF);
    check("rst_busy",  disp_busy, 0);
    check("rst_level", disp_level, 0);
    check("rst_src",   disp_src, 0);

    // single offer: src2 0xAC
    clear_logs();
    offer(4'b0100, 32'h00AC_0000, t);
    wait_ev(1, 20, "single_timeout");
    if (ev_src.size() >= 1) begin
      check("single_lat",   ev_cyc[0] - t, 2);
      check("single_level", ev_lvl[0], 8'hAC);
      check("single_src",   ev_src[0], 2);
    end
    wait_run(20);
    check("single_busy_len", (busy_runs.size() > 0) ? busy_runs[0] : 0, 5);

    // all four simultaneously -> src0..src3, 6 cycles apart
    do_reset();
    offer(4'b1111, 32'h541C_E4AC, t);
    wait_ev(4, 60, "all4_timeout");
    if (ev_src.size() >= 4) begin
      check("all4_lat", ev_cyc[0] - t, 2);
      for (int k = 0; k < 4; k++) check($sformatf("all4_src%0d", k), ev_src[k], k);
      check("all4_lvl0", ev_lvl[0], 8'hAC);
      check("all4_lvl1", ev_lvl[1], 8'hE4);
      check("all4_lvl2", ev_lvl[2], 8'h1C);
      check("all4_lvl3", ev_lvl[3], 8'h54);
      for (int k = 0; k < 3; k++) check($sformatf("all4_gap%0d", k), ev_cyc[k+1] - ev_cyc[k], 6);
    end

    // force to src1 with src0 also pending
    do_reset();
    @(posedge clk); #2 force_en = 1'b1; force_src = 2'd1;
    offer(4'b0011, 32'h0000_2211, t);
    wait_ev(1, 20, "force_timeout");
    if (ev_src.size() >= 1) check("force_first_src", ev_src[0], 1);
    repeat (12) @(negedge clk);
    check("force_hold_count", ev_src.size(), 1);
    check("force_ready0", src_ready[0], 0);
    @(posedge clk); #2 force_en = 1'b0;
    wait_ev(2, 20, "unforce_timeout");
    if (ev_src.size() >= 2) begin
      check("unforce_src", ev_src[1], 0);
      check("unforce_lvl", ev_lvl[1], 8'h11);
    end

    // freeze for 10 cycles during SHOW
    do_reset();
    offer(4'b0100, 32'h005A_0000, t);
    wait_ev(1, 20, "freeze_timeout");
    freeze = 1'b1;
    repeat (10) @(posedge clk);
    #2 freeze = 1'b0;
    wait_run(40);
    check("freeze_busy_len", (busy_runs.size() > 0) ? busy_runs[0] : 0, 15);
    check("freeze_events", ev_src.size(), 1);

    // reset mid-SHOW with src3 pending
    do_reset();
    offer(4'b0010, 32'h0000_1100, t);
    wait_ev(1, 20, "midrst_timeout");
    offer(4'b1000, 32'h3300_0000, t);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    check("midrst_level", disp_level, 0);
    check("midrst_valid", disp_valid, 0);
    check("midrst_src",   disp_src, 0);
    check("midrst_busy",  disp_busy, 0);
    check("midrst_ready", src_ready, 4'hF);
    @(posedge clk); #2 rstn = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    check("midrst_no_grant", ev_src.size(), 0);

    // src1 re-offers during its own SHOW while src2 pending
    do_reset();
    offer(4'b0010, 32'h0000_E400, t);
    wait_ev(1, 20, "rr_timeout");
    offer(4'b0110, 32'h001C_E400, t);
    wait_ev(3, 40, "rr2_timeout");
    if (ev_src.size() >= 3) begin
      check("rr_second_src", ev_src[1], 2);
      check("rr_third_src",  ev_src[2], 1);
      check("rr_third_lvl",  ev_lvl[2], 8'hE4);
    end

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
      end
      src_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      src_level = $urandom;
      force_en  = ($urandom_range(0, 7) == 0);
      force_src = 2'($urandom_range(0, 3));
      freeze    = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #2;
    src_valid = '0; force_en = 0; freeze = 0;
    repeat (60) @(posedge clk);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
